// File: rtl/spw_pkg.sv
// Shared SpaceWire character constants and TX arbiter state type.
// Macro SPW_ARB_TIMEOUT_EN adds the TERM state used for forced EEP on stalled packets.
package spw_pkg;

  localparam int unsigned CHAR_W = 9;

  localparam logic [CHAR_W-1:0] SPW_EOP = 9'h100;
  localparam logic [CHAR_W-1:0] SPW_EEP = 9'h101;

`ifdef SPW_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StPkt, StFlush, StTerm} arb_state_e;
`else
  typedef enum logic [1:0] {StIdle, StPkt, StFlush} arb_state_e;
`endif

endpackage

// File: rtl/spw_rr_pick.sv
// Combinational cyclic priority search: first set bit of req_i at or after ptr_i, wrapping.
module spw_rr_pick #(
  parameter int unsigned  N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned j;

  // Scan from the farthest offset down so the closest hit to ptr_i is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned i = N; i > 0; i--) begin
      j = (32'(ptr_i) + i - 1) % N;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spw_tx_arbiter.sv
// SpaceWire TX arbiter: round-robin, packet-granular sharing of the codec transmit port.
// Define SPW_ARB_TIMEOUT_EN to terminate stalled packets with a forced EEP after TIMEOUT_CYC.
module spw_tx_arbiter
  import spw_pkg::*;
#(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  TIMEOUT_CYC = 1024,
  localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      link_active,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CHAR_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_write,
  output logic [CHAR_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      grant_vld,
  output logic [IDW-1:0]            grant_id,
  output logic                      abort_pulse,
  output logic [15:0]               abort_cnt
);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [CHAR_W-1:0] tx_data_q, tx_data_d;
  logic              abort_pulse_q, abort_pulse_d;
  logic [15:0]       abort_cnt_q, abort_cnt_d;
  logic              abort_inc;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic              g_valid;
  logic [CHAR_W-1:0] g_data;
  logic [IDW-1:0]    next_ptr;

  spw_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign g_valid  = req_valid[grant_id_q];
  assign g_data   = req_data[CHAR_W*int'(grant_id_q) +: CHAR_W];
  assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

`ifdef SPW_ARB_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYC) + 1;
  logic [TOW-1:0] stall_q, stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    abort_pulse_d = 1'b0;
    abort_cnt_d   = abort_cnt_q;
    abort_inc     = 1'b0;
    req_ready     = '0;
    tx_write      = 1'b0;
    tx_data       = tx_data_q;
`ifdef SPW_ARB_TIMEOUT_EN
    stall_d       = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (link_active && pick_found) begin
          grant_id_d = pick_idx;
          state_d    = StPkt;
        end
      end
      StPkt: begin
        if (!link_active) begin
          state_d   = StFlush;
          abort_inc = 1'b1;
        end else begin
          tx_write              = g_valid;
          req_ready[grant_id_q] = tx_ready;
          if (g_valid) begin
            tx_data = g_data;
          end
          if (g_valid && tx_ready) begin
            tx_data_d = g_data;
            if (g_data[CHAR_W-1]) begin
              state_d  = StIdle;
              rr_ptr_d = next_ptr;
            end
          end
`ifdef SPW_ARB_TIMEOUT_EN
          if (!g_valid) begin
            if (stall_q == TOW'(TIMEOUT_CYC - 1)) begin
              state_d   = StTerm;
              abort_inc = 1'b1;
            end else begin
              stall_d = stall_q + TOW'(1);
            end
          end
`endif
        end
      end
      StFlush: begin
        // Drain the aborted packet so the requester can reach its terminator.
        req_ready[grant_id_q] = 1'b1;
        if (g_valid && g_data[CHAR_W-1]) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
`ifdef SPW_ARB_TIMEOUT_EN
      StTerm: begin
        if (!link_active) begin
          state_d = StFlush;
        end else begin
          tx_write = 1'b1;
          tx_data  = SPW_EEP;
          if (tx_ready) begin
            tx_data_d = SPW_EEP;
            state_d   = StFlush;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (abort_inc) begin
      abort_pulse_d = 1'b1;
      if (abort_cnt_q != 16'hFFFF) begin
        abort_cnt_d = abort_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      abort_pulse_q <= 1'b0;
      abort_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      abort_pulse_q <= abort_pulse_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end

  assign grant_vld   = (state_q != StIdle);
  assign grant_id    = grant_id_q;
  assign abort_pulse = abort_pulse_q;
  assign abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_spw_tx_arbiter.sv
// Self-checking bench for spw_tx_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_spw_tx_arbiter;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            link_active = 1'b0;
  logic            tx_ready = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*9-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic            tx_write;
  logic [8:0]      tx_data;
  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            abort_pulse;
  logic [15:0]     abort_cnt;

  always #5 clk = ~clk;

  spw_tx_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_active (link_active),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_write    (tx_write),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id),
    .abort_pulse (abort_pulse),
    .abort_cnt   (abort_cnt)
  );

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic        la;
    logic [3:0]  rv;
    logic [8:0]  d;
    logic        tr;
    logic        gv;
    logic [1:0]  gid;
    logic        tw;
    logic [8:0]  td;
    logic [3:0]  rdy;
    logic        ap;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic la, input logic [3:0] rv, input logic [8:0] d,
                         input logic tr, input logic gv, input logic [1:0] gid,
                         input logic tw, input logic [8:0] td, input logic [3:0] rdy,
                         input logic ap, input logic [15:0] cnt);
    vec_t v;
    v.la = la; v.rv = rv; v.d = d; v.tr = tr; v.gv = gv; v.gid = gid;
    v.tw = tw; v.td = td; v.rdy = rdy; v.ap = ap; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic gv, input logic [1:0] gid,
                         input logic tw, input logic [8:0] td, input logic [3:0] rdy,
                         input logic ap, input logic [15:0] cnt);
    chk({tag, ".grant_vld"}, 16'(grant_vld), 16'(gv));
    chk({tag, ".grant_id"}, 16'(grant_id), 16'(gid));
    chk({tag, ".tx_write"}, 16'(tx_write), 16'(tw));
    chk({tag, ".tx_data"}, 16'(tx_data), 16'(td));
    chk({tag, ".req_ready"}, 16'(req_ready), 16'(rdy));
    chk({tag, ".abort_pulse"}, 16'(abort_pulse), 16'(ap));
    chk({tag, ".abort_cnt"}, abort_cnt, cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, input logic [3:0] rv, input logic [8:0] d,
                       input logic tr);
    link_active = la;
    req_valid   = rv;
    req_data    = {N{d}};
    tx_ready    = tr;
  endtask

  // Reference model state for the random phase
  logic [8:0]  q [N][$];
  logic [8:0]  cur [N];
  bit          m_busy, m_drain, m_pulse;
  int          m_g, m_rr;
  logic [8:0]  m_last;
  logic [15:0] m_cnt;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order[5];
    logic [15:0] exp_cnt;
    order = '{0, 1, 2, 3, 0};

    // Directed table: la rv d tr | gv gid tw td rdy ap cnt
    add_vec(0, 4'hF, 9'h000, 1, 0, 0, 0, 9'h000, 4'h0, 0, 0);
    add_vec(0, 4'hF, 9'h000, 1, 0, 0, 0, 9'h000, 4'h0, 0, 0);
    add_vec(1, 4'h2, 9'h0A5, 1, 0, 0, 0, 9'h000, 4'h0, 0, 0);
    add_vec(1, 4'h2, 9'h0A5, 1, 1, 1, 1, 9'h0A5, 4'h2, 0, 0);
    add_vec(1, 4'h2, 9'h03C, 0, 1, 1, 1, 9'h03C, 4'h0, 0, 0);
    add_vec(1, 4'h2, 9'h03C, 1, 1, 1, 1, 9'h03C, 4'h2, 0, 0);
    add_vec(1, 4'h2, 9'h100, 1, 1, 1, 1, 9'h100, 4'h2, 0, 0);
    add_vec(1, 4'h0, 9'h100, 1, 0, 1, 0, 9'h100, 4'h0, 0, 0);
    add_vec(1, 4'h3, 9'h100, 1, 0, 1, 0, 9'h100, 4'h0, 0, 0);
    add_vec(1, 4'h3, 9'h100, 1, 1, 0, 1, 9'h100, 4'h1, 0, 0);
    add_vec(1, 4'h3, 9'h100, 1, 0, 0, 0, 9'h100, 4'h0, 0, 0);
    add_vec(1, 4'h3, 9'h100, 1, 1, 1, 1, 9'h100, 4'h2, 0, 0);
    add_vec(1, 4'h0, 9'h100, 1, 0, 1, 0, 9'h100, 4'h0, 0, 0);
    add_vec(1, 4'h8, 9'h055, 1, 0, 1, 0, 9'h100, 4'h0, 0, 0);
    add_vec(1, 4'h8, 9'h055, 1, 1, 3, 1, 9'h055, 4'h8, 0, 0);
    add_vec(0, 4'h8, 9'h066, 1, 1, 3, 0, 9'h055, 4'h0, 0, 0);
    add_vec(1, 4'h8, 9'h077, 1, 1, 3, 0, 9'h055, 4'h8, 1, 1);
    add_vec(1, 4'h8, 9'h100, 1, 1, 3, 0, 9'h055, 4'h8, 0, 1);
    add_vec(1, 4'h0, 9'h100, 1, 0, 3, 0, 9'h055, 4'h0, 0, 1);

    // Reset values while reset is held
    #3;
    chk_all("reset", 0, 0, 0, 9'h000, 4'h0, 0, 16'd0);
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].la, vecs[i].rv, vecs[i].d, vecs[i].tr);
      #3;
      chk_all($sformatf("vec%0d", i), vecs[i].gv, vecs[i].gid, vecs[i].tw, vecs[i].td,
              vecs[i].rdy, vecs[i].ap, vecs[i].cnt);
      tick();
    end
    exp_cnt = 16'd1;

    // Fairness: one-char packets from everyone, bubble between grants
    drive(1, 4'hF, 9'h100, 1);
    for (int k = 0; k < 10; k++) begin
      #3;
      chk("fair.grant_vld", 16'(grant_vld), 16'(k % 2));
      if (k % 2 == 1) begin
        chk("fair.grant_id", 16'(grant_id), 16'(order[k / 2]));
        chk("fair.tx_write", 16'(tx_write), 16'd1);
      end
      tick();
    end
    drive(1, 4'h0, 9'h100, 1);
    tick();

    // Stall mid-packet: timeout forces EEP, otherwise grant is held
    drive(1, 4'h2, 9'h0AA, 1);
    #3;
    chk("stall.idle_gv", 16'(grant_vld), 16'd0);
    tick();
    #3;
    chk_all("stall.first", 1, 1, 1, 9'h0AA, 4'h2, 0, exp_cnt);
    tick();
    drive(1, 4'h0, 9'h0AA, 1);
    for (int k = 0; k < 16; k++) begin
      #3;
      chk("stall.tx_write", 16'(tx_write), 16'd0);
      chk("stall.grant_vld", 16'(grant_vld), 16'd1);
      tick();
    end
`ifdef SPW_ARB_TIMEOUT_EN
    #3;
    exp_cnt = exp_cnt + 16'd1;
    chk_all("to.term", 1, 1, 1, 9'h101, 4'h0, 1, exp_cnt);
    tick();
    drive(1, 4'h2, 9'h0BB, 1);
    #3;
    chk_all("to.flush", 1, 1, 0, 9'h101, 4'h2, 0, exp_cnt);
    tick();
    drive(1, 4'h2, 9'h100, 1);
    #3;
    chk_all("to.flush_eop", 1, 1, 0, 9'h101, 4'h2, 0, exp_cnt);
    tick();
`else
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("hold.grant_vld", 16'(grant_vld), 16'd1);
      tick();
    end
    drive(1, 4'h2, 9'h100, 1);
    #3;
    chk_all("hold.eop", 1, 1, 1, 9'h100, 4'h2, 0, exp_cnt);
    tick();
`endif
    drive(1, 4'h0, 9'h000, 1);
    #3;
    chk("stall.release", 16'(grant_vld), 16'd0);
    tick();

    // Asynchronous reset in the middle of a packet
    drive(1, 4'h1, 9'h0AB, 0);
    tick();
    #3;
    chk("mreset.pre_gv", 16'(grant_vld), 16'd1);
    chk("mreset.pre_gid", 16'(grant_id), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mreset", 0, 0, 0, 9'h000, 4'h0, 0, 16'd0);
    drive(0, 4'h0, 9'h000, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    m_busy = 0; m_drain = 0; m_pulse = 0; m_g = 0; m_rr = 0;
    m_last = '0; m_cnt = '0;
    link_active = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        n_pulse;
      int          pop;
      logic        e_tw;
      logic [8:0]  e_td;
      logic [3:0]  e_rdy;

      if (link_active) link_active = ($urandom_range(0, 49) != 0);
      else             link_active = ($urandom_range(0, 3) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 5);
          for (int b = 0; b < len - 1; b++) q[i].push_back({1'b0, 8'($urandom)});
          q[i].push_back(($urandom_range(0, 3) == 0) ? 9'h101 : 9'h100);
        end
        req_valid[i] = (q[i].size() > 0) && ($urandom_range(0, 4) != 0);
        cur[i] = (q[i].size() > 0) ? q[i][0] : 9'($urandom);
        req_data[i*9 +: 9] = cur[i];
      end
      #3;

      e_tw = 1'b0; e_td = m_last; e_rdy = '0; n_pulse = 1'b0; pop = -1;
      chk("rnd.grant_vld", 16'(grant_vld), 16'(m_busy));
      chk("rnd.grant_id", 16'(grant_id), 16'(m_g));
      chk("rnd.abort_pulse", 16'(abort_pulse), 16'(m_pulse));
      chk("rnd.abort_cnt", abort_cnt, m_cnt);
      if (!m_busy) begin
        if (link_active) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(m_rr + k) % N]) begin
              m_g    = (m_rr + k) % N;
              m_busy = 1;
            end
          end
          m_drain = 0;
        end
      end else if (!m_drain) begin
        if (!link_active) begin
          m_drain = 1;
          n_pulse = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          e_tw = req_valid[m_g];
          e_rdy[m_g] = tx_ready;
          if (req_valid[m_g]) e_td = cur[m_g];
          if (req_valid[m_g] && tx_ready) begin
            m_last = cur[m_g];
            pop = m_g;
          end
        end
      end else begin
        e_rdy[m_g] = 1'b1;
        if (req_valid[m_g]) pop = m_g;
      end
      chk("rnd.tx_write", 16'(tx_write), 16'(e_tw));
      chk("rnd.tx_data", 16'(tx_data), 16'(e_td));
      chk("rnd.req_ready", 16'(req_ready), 16'(e_rdy));
      if (pop >= 0) begin
        void'(q[pop].pop_front());
        if (cur[pop][8]) begin
          m_busy  = 0;
          m_drain = 0;
          m_rr    = (m_g + 1) % N;
        end
      end
      m_pulse = n_pulse;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
